// File: rtl/trace_capture.sv
// trace_capture: writer side of the scope trace RAM.
// It decimates a 12-bit ADC stream and waits for a level-crossing trigger.
// It then writes NPTS screen-Y values to addresses 0..NPTS-1.
// After a capture it holds until the next display vsync rising edge,
// so the display never shows a half-rewritten trace.
// Optional feature macro: TRACE_AUTO_TRIG_EN. When it is defined, ARMED forces
// a capture after AUTO_TIMEOUT accepted samples have arrived without a trigger.
`timescale 1ns/1ps

module trace_capture #(
    parameter int NPTS         = 640,
    parameter int YMAX         = 479,
    parameter int SHIFT        = 3,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic [7:0]  decim,
    input  logic [11:0] trig_level,
    input  logic        trig_falling,
    input  logic        run,
    input  logic        vsync,
    output logic [9:0]  waddr,
    output logic [8:0]  wdata,
    output logic        we,
    output logic        triggered,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [9:0]  LAST_ADDR = 10'(NPTS - 1);
    localparam logic [11:0] YMAX_W    = 12'(YMAX);

    state_t      state_q, state_d;
    logic [7:0]  dec_cnt_q, dec_cnt_d;
    logic [11:0] prev_q, prev_d;
    logic        first_q, first_d;       // prev not yet loaded in this ARMED visit
    logic [9:0]  wptr_q, wptr_d;         // next capture address to write
    logic [9:0]  waddr_q, waddr_d;
    logic [8:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        triggered_q, triggered_d;
    logic        done_q, done_d;
    logic        vsync_dly_q, vsync_dly_d;

    logic        active;
    logic        accept;
    logic [11:0] shifted;
    logic [8:0]  y_val;
    logic        hit;
    logic        vsync_edge;
    logic        arm;
    logic        auto_fire;

    // Only ARMED and CAPTURE look at the sample stream.
    assign active     = (state_q == ARMED) || (state_q == CAPTURE);
    assign accept     = active && sample_valid && (dec_cnt_q == decim);
    assign vsync_edge = vsync && !vsync_dly_q;

    // Sample to screen row. Codes whose shifted value is at or past YMAX
    // clamp to the top row (0).
    assign shifted = sample >> SHIFT;
    assign y_val   = (shifted >= YMAX_W) ? 9'd0 : 9'(YMAX_W - shifted);

    // A level crossing counts only once prev holds a sample from this arming.
    assign hit = !first_q &&
                 (trig_falling ? ((prev_q >= trig_level) && (sample <  trig_level))
                               : ((prev_q <  trig_level) && (sample >= trig_level)));

`ifdef TRACE_AUTO_TRIG_EN
    localparam int AW = $clog2(AUTO_TIMEOUT + 1);
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;

    // When the count already holds AUTO_TIMEOUT-1, the current accepted
    // sample is the timeout-th one.
    assign auto_fire = (auto_cnt_q == AW'(AUTO_TIMEOUT - 1));

    // Accepted-sample counter for the forced trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) auto_cnt_q <= '0;
        else        auto_cnt_q <= auto_cnt_d;
    end
`else
    assign auto_fire = 1'b0;
`endif

    // Next-state, decimation, trigger and RAM write logic.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d     = state_q;
        dec_cnt_d   = dec_cnt_q;
        prev_d      = prev_q;
        first_d     = first_q;
        wptr_d      = wptr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        triggered_d = triggered_q;
        done_d      = 1'b0;
        vsync_dly_d = vsync;
        arm         = 1'b0;
`ifdef TRACE_AUTO_TRIG_EN
        auto_cnt_d  = auto_cnt_q;
`endif

        if (active && sample_valid) begin
            dec_cnt_d = (dec_cnt_q == decim) ? 8'd0 : dec_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (run) arm = 1'b1;
            end
            ARMED: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (accept) begin
                    prev_d  = sample;
                    first_d = 1'b0;
`ifdef TRACE_AUTO_TRIG_EN
                    auto_cnt_d = auto_cnt_q + 1'b1;
`endif
                    if (hit || auto_fire) begin
                        state_d     = CAPTURE;
                        triggered_d = 1'b1;
                        waddr_d     = 10'd0;
                        wdata_d     = y_val;
                        we_d        = 1'b1;
                        wptr_d      = 10'd1;
                    end
                end
            end
            CAPTURE: begin
                // run is deliberately ignored here so a capture always completes.
                if (accept) begin
                    waddr_d = wptr_q;
                    wdata_d = y_val;
                    we_d    = 1'b1;
                    if (wptr_q == LAST_ADDR) begin
                        state_d     = HOLD;
                        done_d      = 1'b1;
                        triggered_d = 1'b0;
                    end else begin
                        wptr_d = wptr_q + 10'd1;
                    end
                end
            end
            HOLD: begin
                // An edge that coincides with the done pulse is not used.
                // That frame may already have been showing the old trace.
                if (vsync_edge && !done_q) begin
                    if (run) arm = 1'b1;
                    else     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arm) begin
            state_d   = ARMED;
            dec_cnt_d = 8'd0;
            first_d   = 1'b1;
`ifdef TRACE_AUTO_TRIG_EN
            auto_cnt_d = '0;
`endif
        end
    end

    // State and registered RAM-port flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dec_cnt_q   <= 8'd0;
            prev_q      <= 12'd0;
            first_q     <= 1'b0;
            wptr_q      <= 10'd0;
            waddr_q     <= 10'd0;
            wdata_q     <= 9'd0;
            we_q        <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            vsync_dly_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state_q     <= state_d;
            dec_cnt_q   <= dec_cnt_d;
            prev_q      <= prev_d;
            first_q     <= first_d;
            wptr_q      <= wptr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            vsync_dly_q <= vsync_dly_d;
        end
    end

    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign we        = we_q;
    assign triggered = triggered_q;
    assign done      = done_q;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: scoreboard of expected RAM writes,
// table-driven Y-mapping vectors and hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_trace_capture;

    localparam int NPTS    = 640;
    localparam int AUTO_TO = 50;

    localparam int S_IDLE    = 0;
    localparam int S_ARMED   = 1;
    localparam int S_HOLD    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = 12'd0;
    logic [7:0]  decim = 8'd0;
    logic [11:0] trig_level = 12'd2048;
    logic        trig_falling = 1'b0;
    logic        run = 1'b0;
    logic        vsync = 1'b0;
    logic [9:0]  waddr;
    logic [8:0]  wdata;
    logic        we;
    logic        triggered;
    logic        done;

    trace_capture #(.NPTS(NPTS), .YMAX(479), .SHIFT(3), .AUTO_TIMEOUT(AUTO_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .decim        (decim),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .run          (run),
        .vsync        (vsync),
        .waddr        (waddr),
        .wdata        (wdata),
        .we           (we),
        .triggered    (triggered),
        .done         (done)
    );

    always #10 clk = ~clk;

    typedef struct {
        int addr;
        int y;
    } exp_t;

    typedef struct {
        logic [11:0] smp;
        int          exp_y;
    } vec_t;

    exp_t sb[$];
    vec_t tab[8];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_writes = 0;
    int last_we_cyc = 0;
    int first_we_cyc = 0;
    int exp_gap = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int y_ref(input int s);
        int sh;
        sh = s >> 3;
        return (sh >= 479) ? 0 : 479 - sh;
    endfunction

    // Sample generators, indexed by strobe number j within one stream.
    function automatic logic [11:0] gen(input int kind, input int j);
        case (kind)
            0:       return 12'((j % 16) * 256);
            1:       return (j % 4 == 3) ? 12'(3840 - ((j / 4) % 16) * 256) : 12'd0;
            2:       return (j == 0) ? 12'd0 : (j == 1) ? 12'd2048 : tab[(j - 2) % 8].smp;
            default: return 12'd100;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && we) begin
            n_writes++;
            if (sb.size() == 0) begin
                fail("unexpected_write");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.y);
                check("done_on_write", done, (e.addr == NPTS - 1) ? 1 : 0);
                check("triggered", triggered, (e.addr == NPTS - 1) ? 0 : 1);
                if (e.addr != 0) check("we_gap", cyc - last_we_cyc, exp_gap);
                else             first_we_cyc = cyc;
            end
            last_we_cyc = cyc;
        end else if (rst_n && done) begin
            fail("done_without_write");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one valid sample per cycle until the scoreboard drains or the budget runs out.
    task automatic stream(input int kind, input int budget, input int drop_run_after);
        int j;
        int w0;
        j  = 0;
        w0 = n_writes;
        while (sb.size() != 0 && j < budget) begin
            if (drop_run_after > 0 && n_writes - w0 >= drop_run_after) run = 1'b0;
            sample       = gen(kind, j);
            sample_valid = 1'b1;
            j++;
            tick();
        end
        sample_valid = 1'b0;
        if (sb.size() != 0) begin
            fail("stream_timeout");
            sb.delete();
        end
    endtask

    // Drive samples for a while and require that no write happens.
    task automatic quiet_window(input string name, input int kind, input int cycles);
        int w0;
        w0 = n_writes;
        for (int i = 0; i < cycles; i++) begin
            sample       = gen(kind, i);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        check(name, n_writes - w0, 0);
    endtask

    task automatic vsync_edge(input string name, input int exp_state);
        vsync = 1'b1;
        tick();
        check(name, 32'(dut.state_q), exp_state);
        vsync = 1'b0;
        tick();
    endtask

    task automatic push_ramp();
        for (int i = 0; i < NPTS; i++) sb.push_back('{i, y_ref(((8 + i) % 16) * 256)});
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0;
        int n0;
        int j;

        tab[0] = '{12'd4095, 0};
        tab[1] = '{12'd0,    479};
        tab[2] = '{12'd3840, 0};
        tab[3] = '{12'd2048, 223};
        tab[4] = '{12'd100,  467};
        tab[5] = '{12'd8,    478};
        tab[6] = '{12'd3839, 0};
        tab[7] = '{12'd3831, 1};

        // Reset state.
        #25;
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_we", we, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_without_run", 32'(dut.state_q), S_IDLE);

        // Rising trigger on a ramp, every sample accepted.
        run = 1'b1;
        tick();
        check("idle_to_armed", 32'(dut.state_q), S_ARMED);
        push_ramp();
        exp_gap = 1;
        stream(0, 2000, 0);
        check("capture1_hold", 32'(dut.state_q), S_HOLD);

        // HOLD ignores samples until vsync rises.
        quiet_window("hold_no_writes", 0, 5000);
        trig_falling = 1'b1;
        decim        = 8'd3;
        vsync_edge("hold_to_armed", S_ARMED);

        // Falling trigger with decimation by 4.
        for (int i = 0; i < NPTS; i++) sb.push_back('{i, y_ref(3840 - ((8 + i) % 16) * 256)});
        exp_gap = 4;
        stream(1, 4000, 0);
        check("capture2_hold", 32'(dut.state_q), S_HOLD);

        // Clamp vectors; run dropped after 100 writes must not cut the capture short.
        trig_falling = 1'b0;
        decim        = 8'd0;
        vsync_edge("hold_to_armed2", S_ARMED);
        sb.push_back('{0, 223});
        for (int i = 1; i < NPTS; i++) sb.push_back('{i, tab[(i - 1) % 8].exp_y});
        exp_gap = 1;
        stream(2, 2000, 100);
        check("capture3_hold", 32'(dut.state_q), S_HOLD);
        vsync_edge("hold_to_idle", S_IDLE);
        quiet_window("idle_no_writes", 0, 200);

        // DC input: only the forced trigger can start a capture.
        run = 1'b1;
        tick();
        check("idle_to_armed_dc", 32'(dut.state_q), S_ARMED);
`ifdef TRACE_AUTO_TRIG_EN
        for (int i = 0; i < NPTS; i++) sb.push_back('{i, 467});
        n0 = cyc;
        stream(3, 2000, 0);
        check("auto_first_write_cycle", first_we_cyc, n0 + AUTO_TO);
`else
        n0 = cyc;
        quiet_window("dc_no_writes", 3, 2000);
        check("dc_still_armed", 32'(dut.state_q), S_ARMED);
`endif

        // Reset in the middle of a capture.
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", 32'(dut.state_q), S_IDLE);
        run = 1'b1;
        tick();
        check("reset_test_armed", 32'(dut.state_q), S_ARMED);
        push_ramp();
        w0 = n_writes;
        j  = 0;
        while (n_writes - w0 < 100 && j < 1000) begin
            sample       = gen(0, j);
            sample_valid = 1'b1;
            j++;
            tick();
        end
        check("writes_before_reset", (n_writes - w0 >= 100) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we", we, 0);
        check("midrst_waddr", waddr, 0);
        check("midrst_triggered", triggered, 0);
        check("midrst_done", done, 0);
        sb.delete();
        sample_valid = 1'b0;
        run          = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("midrst_idle", 32'(dut.state_q), S_IDLE);
        run = 1'b1;
        tick();
        check("midrst_rearm", 32'(dut.state_q), S_ARMED);
        run = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
